exu_dispatch: RTL and testbench
===============================

EXU_DISPATCH -- requirements
Module: exu_dispatch

Interface
REQ-001 Parameter TAG_DEPTH, default 4, power of two >=2: depth of in-order destination-tag FIFO.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 flush_i  in  1  pipeline flush; kills all held and in-flight ops.
REQ-005 dec_valid_i  in  1 / dec_ready_o  out  1  decode-side valid/ready.
REQ-006 opr_a_i, opr_b_i  in  64 each; exu_func_i  in  4; word_op_i, mul_instr_i, div_instr_i  in  1 each: op payload.
REQ-007 rd_i  in  5 destination register; rd_wen_i  in  1 destination write enable.
REQ-008 valid_instr_o  out  1 / exu_ready_i  in  1  execute-side issue handshake.
REQ-009 opr_a_o, opr_b_o  out  64; exu_func_o  out  4; word_op_o, mul_instr_o, div_instr_o  out  1: registered payload to execute.
REQ-010 valid_res_i  in  1 / res_ready_o  out  1; exu_res_i  in  64: execute result handshake.
REQ-011 wb_en_o  out  1; wb_rd_o  out  5; wb_data_o  out  64: registered register-file write port.
REQ-012 busy_o  out  32: scoreboard, bit n set = register n has pending write.

Function
REQ-013 Issue register: one entry (payload, rd, rd_wen, issue_valid); loads on dec_valid_i & dec_ready_o.
REQ-014 dec_ready_o = ~issue_valid | issue_fire; depends on exu_ready_i combinationally.
REQ-015 valid_instr_o = issue_valid & ~tag_full; issue_fire = valid_instr_o & exu_ready_i.
REQ-016 Payload outputs SHALL be stable while issue_valid & ~issue_fire.
REQ-017 On issue_fire, push {rd, rd_wen} to tag FIFO; load and fire same cycle allowed (back-to-back, 1 op/cycle).
REQ-018 res_ready_o = ~tag_empty | valid_instr_o; SHALL NOT depend on exu_ready_i (execute's ready depends on res_ready_o).
REQ-019 res_fire = valid_res_i & res_ready_o; pops one tag; tag = FIFO head if non-empty, else bypass of the tag being pushed this cycle (same-cycle ALU result).
REQ-020 Results pair with tags strictly in issue order.
REQ-021 Simultaneous push and pop: count unchanged; push allowed when full only if pop same cycle is not relied on (full blocks issue).
REQ-022 Writeback: cycle after res_fire, wb_en_o = tag.rd_wen & (tag.rd != 0), wb_rd_o = tag.rd, wb_data_o = exu_res_i captured; wb_en_o low otherwise.
REQ-023 Scoreboard: set bit rd on issue_fire when rd_wen & rd!=0; clear bit on wb_en_o cycle; same-register set and clear same cycle -> set wins.
REQ-024 busy_o[0] SHALL always be 0.
REQ-025 Pointers wrap modulo TAG_DEPTH; full = count==TAG_DEPTH, empty = count==0.
REQ-026 flush_i (synchronous, priority over all): clear issue_valid, empty FIFO, clear busy_o, suppress res_fire tag effects, force wb_en_o=0 next cycle; dec_ready_o and res_ready_o asserted during flush cycle (result data dropped).
REQ-027 Result arriving with empty FIFO and no valid_instr_o: not accepted (res_ready_o=0).

Reset
REQ-028 resetn low asynchronously: issue_valid=0, FIFO empty, pointers 0, busy_o=0, wb_en_o=0, wb_rd_o=0, wb_data_o=0, payload outputs 0.
REQ-029 Outputs after reset: valid_instr_o=0, dec_ready_o=1, res_ready_o=0; reset mid-operation discards all in-flight tags.

Verification
REQ-030 ALU op rd=5, rd_wen=1, same-cycle valid_res_i=1, data 0x1234 -> next cycle wb_en_o=1, wb_rd_o=5, wb_data_o=0x1234; busy_o[5] high one cycle then clear.
REQ-031 MUL rd=3 then ALU rd=4, exu_ready_i low 3 cycles after MUL -> ALU held stable, results write rd 3 then rd 4 in order.
REQ-032 Issue 4 ops with valid_res_i=0 (TAG_DEPTH=4) -> valid_instr_o=0 while full; one result pops -> issue resumes next cycle.
REQ-033 Op rd=0, rd_wen=1 -> busy_o unchanged, wb_en_o=0.
REQ-034 Flush with 2 tags pending and issue_valid=1 -> next cycle busy_o=0, valid_instr_o=0, subsequent late valid_res_i not accepted.
REQ-035 resetn pulsed low mid-DIV -> all outputs reach REQ-028 values immediately, no wb_en_o after release.

Source files
------------

// File: rtl/exu_dispatch_if.sv
// Decode-to-execute dispatch bundle: decode handshake, issue payload, result
// return, register-file writeback and the pending-write scoreboard.
interface exu_dispatch_if;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [63:0] opr_a_i;
  logic [63:0] opr_b_i;
  logic [3:0]  exu_func_i;
  logic        word_op_i;
  logic        mul_instr_i;
  logic        div_instr_i;
  logic [4:0]  rd_i;
  logic        rd_wen_i;

  logic        valid_instr_o;
  logic        exu_ready_i;
  logic [63:0] opr_a_o;
  logic [63:0] opr_b_o;
  logic [3:0]  exu_func_o;
  logic        word_op_o;
  logic        mul_instr_o;
  logic        div_instr_o;

  logic        valid_res_i;
  logic        res_ready_o;
  logic [63:0] exu_res_i;

  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic [31:0] busy_o;

  modport slave (
    input  dec_valid_i, opr_a_i, opr_b_i, exu_func_i, word_op_i, mul_instr_i,
           div_instr_i, rd_i, rd_wen_i, exu_ready_i, valid_res_i, exu_res_i,
    output dec_ready_o, valid_instr_o, opr_a_o, opr_b_o, exu_func_o, word_op_o,
           mul_instr_o, div_instr_o, res_ready_o, wb_en_o, wb_rd_o, wb_data_o,
           busy_o
  );

  modport master (
    output dec_valid_i, opr_a_i, opr_b_i, exu_func_i, word_op_i, mul_instr_i,
           div_instr_i, rd_i, rd_wen_i, exu_ready_i, valid_res_i, exu_res_i,
    input  dec_ready_o, valid_instr_o, opr_a_o, opr_b_o, exu_func_o, word_op_o,
           mul_instr_o, div_instr_o, res_ready_o, wb_en_o, wb_rd_o, wb_data_o,
           busy_o
  );
endinterface

// File: rtl/exu_dispatch.sv
// Single-entry issue stage with an in-order destination-tag FIFO that pairs
// execute results with their destinations, plus a pending-write scoreboard.
module exu_dispatch #(
  parameter int TAG_DEPTH = 4
) (
  input logic         clk,
  input logic         resetn,
  input logic         flush_i,
  exu_dispatch_if.slave bus
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic        issue_valid_reg;
  logic [63:0] opr_a_reg;
  logic [63:0] opr_b_reg;
  logic [3:0]  func_reg;
  logic        word_op_reg;
  logic        mul_reg;
  logic        div_reg;
  logic [4:0]  rd_reg;
  logic        rd_wen_reg;

  logic [4:0]    tag_rd_mem  [TAG_DEPTH];
  logic          tag_wen_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic        wb_en_reg;
  logic [4:0]  wb_rd_reg;
  logic [63:0] wb_data_reg;

  logic tag_full;
  logic tag_empty;
  logic valid_instr;
  logic issue_fire;
  logic dec_ready;
  logic dec_fire;
  logic res_ready;
  logic res_fire;
  logic bypass;
  logic push;
  logic pop;
  logic [4:0] pop_rd;
  logic       pop_wen;

  assign tag_full  = (count_reg == CW'(TAG_DEPTH));
  assign tag_empty = (count_reg == '0);

  // Nothing issues during a flush so a killed op never reaches execute.
  assign valid_instr = issue_valid_reg & ~tag_full & ~flush_i;
  assign issue_fire  = valid_instr & bus.exu_ready_i;
  assign dec_ready   = flush_i | ~issue_valid_reg | issue_fire;
  assign dec_fire    = bus.dec_valid_i & dec_ready & ~flush_i;

  // Execute's ready may depend on res_ready, so keep exu_ready_i out of it.
  assign res_ready = flush_i | ~tag_empty | valid_instr;
  assign res_fire  = bus.valid_res_i & res_ready & ~flush_i;

  // An empty FIFO means the result belongs to the op issuing right now.
  assign bypass  = res_fire & tag_empty;
  assign push    = issue_fire & ~bypass;
  assign pop     = res_fire & ~tag_empty;
  assign pop_rd  = tag_empty ? rd_reg     : tag_rd_mem[rd_ptr_reg];
  assign pop_wen = tag_empty ? rd_wen_reg : tag_wen_mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_valid_reg <= 1'b0;
      opr_a_reg       <= '0;
      opr_b_reg       <= '0;
      func_reg        <= '0;
      word_op_reg     <= 1'b0;
      mul_reg         <= 1'b0;
      div_reg         <= 1'b0;
      rd_reg          <= '0;
      rd_wen_reg      <= 1'b0;
    end else if (flush_i) begin
      issue_valid_reg <= 1'b0;
    end else if (dec_fire) begin
      issue_valid_reg <= 1'b1;
      opr_a_reg       <= bus.opr_a_i;
      opr_b_reg       <= bus.opr_b_i;
      func_reg        <= bus.exu_func_i;
      word_op_reg     <= bus.word_op_i;
      mul_reg         <= bus.mul_instr_i;
      div_reg         <= bus.div_instr_i;
      rd_reg          <= bus.rd_i;
      rd_wen_reg      <= bus.rd_wen_i;
    end else if (issue_fire) begin
      issue_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_rd_mem[wr_ptr_reg]  <= rd_reg;
      tag_wen_mem[wr_ptr_reg] <= rd_wen_reg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_en_reg   <= 1'b0;
      wb_rd_reg   <= '0;
      wb_data_reg <= '0;
    end else begin
      wb_en_reg <= res_fire & pop_wen & (pop_rd != 5'd0);
      if (res_fire) begin
        wb_rd_reg   <= pop_rd;
        wb_data_reg <= bus.exu_res_i;
      end
    end
  end

  // Register 0 is never tracked; a set on issue outranks a same-cycle clear.
  assign bus.busy_o[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      logic busy_bit_reg;
      logic set_bit;
      logic clr_bit;
      assign set_bit = issue_fire & rd_wen_reg & (rd_reg == 5'(gi));
      assign clr_bit = wb_en_reg & (wb_rd_reg == 5'(gi));
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      busy_bit_reg <= 1'b0;
        else if (flush_i) busy_bit_reg <= 1'b0;
        else if (set_bit) busy_bit_reg <= 1'b1;
        else if (clr_bit) busy_bit_reg <= 1'b0;
      end
      assign bus.busy_o[gi] = busy_bit_reg;
    end
  endgenerate

  assign bus.dec_ready_o   = dec_ready;
  assign bus.valid_instr_o = valid_instr;
  assign bus.res_ready_o   = res_ready;
  assign bus.opr_a_o       = opr_a_reg;
  assign bus.opr_b_o       = opr_b_reg;
  assign bus.exu_func_o    = func_reg;
  assign bus.word_op_o     = word_op_reg;
  assign bus.mul_instr_o   = mul_reg;
  assign bus.div_instr_o   = div_reg;
  assign bus.wb_en_o       = wb_en_reg;
  assign bus.wb_rd_o       = wb_rd_reg;
  assign bus.wb_data_o     = wb_data_reg;
endmodule

// File: tb/tb_exu_dispatch.sv
// Directed bench for exu_dispatch: ALU vector table plus hand-built sequences
// for stalls, tag-FIFO full, flush and asynchronous reset.
module tb_exu_dispatch;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush_i = 1'b0;
  int checks = 0;
  int failures = 0;

  exu_dispatch_if bus();

  exu_dispatch #(.TAG_DEPTH(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] a;
    logic [63:0] res;
    logic        exp_en;
    logic [31:0] exp_busy;
  } alu_vec_t;

  alu_vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] rd, input logic wen, input logic [63:0] a,
                          input logic [3:0] func, input logic mul, input logic div);
    bus.dec_valid_i = 1'b1;
    bus.rd_i        = rd;
    bus.rd_wen_i    = wen;
    bus.opr_a_i     = a;
    bus.opr_b_i     = ~a;
    bus.exu_func_i  = func;
    bus.word_op_i   = 1'b0;
    bus.mul_instr_i = mul;
    bus.div_instr_i = div;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dec_valid_i = 1'b0; bus.opr_a_i = '0; bus.opr_b_i = '0; bus.exu_func_i = '0;
    bus.word_op_i = 1'b0; bus.mul_instr_i = 1'b0; bus.div_instr_i = 1'b0;
    bus.rd_i = '0; bus.rd_wen_i = 1'b0; bus.exu_ready_i = 1'b0;
    bus.valid_res_i = 1'b0; bus.exu_res_i = '0;

    vecs[0] = '{rd: 5'd5,  wen: 1'b1, a: 64'h1111,      res: 64'h1234,      exp_en: 1'b1, exp_busy: 32'h0000_0020};
    vecs[1] = '{rd: 5'd0,  wen: 1'b1, a: 64'h2222,      res: 64'hBEEF,      exp_en: 1'b0, exp_busy: 32'h0000_0000};
    vecs[2] = '{rd: 5'd7,  wen: 1'b0, a: 64'h3333,      res: 64'h77,        exp_en: 1'b0, exp_busy: 32'h0000_0000};
    vecs[3] = '{rd: 5'd31, wen: 1'b1, a: 64'hFFFF_0000, res: '1,            exp_en: 1'b1, exp_busy: 32'h8000_0000};
    vecs[4] = '{rd: 5'd1,  wen: 1'b1, a: 64'h5555,      res: 64'h1_0000_0000, exp_en: 1'b1, exp_busy: 32'h0000_0002};

    // Reset values
    repeat (2) tick();
    check("rst_valid_instr", bus.valid_instr_o, 0);
    check("rst_dec_ready", bus.dec_ready_o, 1);
    check("rst_res_ready", bus.res_ready_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_wb_en", bus.wb_en_o, 0);
    check("rst_opr_a", bus.opr_a_o, 0);
    resetn = 1'b1;
    $display("txn reset done");

    // ALU ops with the result returned in the issue cycle
    for (int i = 0; i < 5; i++) begin
      tick();
      drive_op(vecs[i].rd, vecs[i].wen, vecs[i].a, 4'h1, 1'b0, 1'b0);
      #1 check("alu_dec_ready", bus.dec_ready_o, 1);
      tick();
      bus.dec_valid_i = 1'b0; bus.exu_ready_i = 1'b1;
      bus.valid_res_i = 1'b1; bus.exu_res_i = vecs[i].res;
      #1;
      check("alu_valid_instr", bus.valid_instr_o, 1);
      check("alu_opr_a", bus.opr_a_o, vecs[i].a);
      check("alu_opr_b", bus.opr_b_o, ~vecs[i].a);
      check("alu_res_ready", bus.res_ready_o, 1);
      tick();
      bus.exu_ready_i = 1'b0; bus.valid_res_i = 1'b0;
      check("alu_wb_en", bus.wb_en_o, vecs[i].exp_en);
      if (vecs[i].exp_en) begin
        check("alu_wb_rd", bus.wb_rd_o, vecs[i].rd);
        check("alu_wb_data", bus.wb_data_o, vecs[i].res);
      end
      check("alu_busy_set", bus.busy_o, vecs[i].exp_busy);
      tick();
      check("alu_busy_clr", bus.busy_o, 0);
      check("alu_wb_idle", bus.wb_en_o, 0);
      $display("txn alu rd=%0d wen=%0d res=0x%0h", vecs[i].rd, vecs[i].wen, vecs[i].res);
    end

    // MUL rd3 then ALU rd4 with execute stalled three cycles
    tick();
    drive_op(5'd3, 1'b1, 64'hAAAA, 4'h2, 1'b1, 1'b0);
    tick();
    drive_op(5'd4, 1'b1, 64'hBBBB, 4'h1, 1'b0, 1'b0);
    bus.exu_ready_i = 1'b1;
    #1;
    check("mul_valid_instr", bus.valid_instr_o, 1);
    check("mul_flag", bus.mul_instr_o, 1);
    check("mul_dec_ready", bus.dec_ready_o, 1);
    tick();
    bus.dec_valid_i = 1'b0; bus.exu_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_opr_a", bus.opr_a_o, 64'hBBBB);
      check("stall_valid_instr", bus.valid_instr_o, 1);
      check("stall_mul_flag", bus.mul_instr_o, 0);
      check("stall_busy", bus.busy_o, 32'h8);
      tick();
    end
    bus.valid_res_i = 1'b1; bus.exu_res_i = 64'h33;
    #1 check("mul_res_ready", bus.res_ready_o, 1);
    tick();
    check("mul_wb_en", bus.wb_en_o, 1);
    check("mul_wb_rd", bus.wb_rd_o, 3);
    check("mul_wb_data", bus.wb_data_o, 64'h33);
    check("mul_busy", bus.busy_o, 32'h8);
    bus.exu_ready_i = 1'b1; bus.valid_res_i = 1'b1; bus.exu_res_i = 64'h44;
    #1 check("alu2_res_ready", bus.res_ready_o, 1);
    tick();
    bus.exu_ready_i = 1'b0; bus.valid_res_i = 1'b0;
    check("alu2_wb_en", bus.wb_en_o, 1);
    check("alu2_wb_rd", bus.wb_rd_o, 4);
    check("alu2_wb_data", bus.wb_data_o, 64'h44);
    check("alu2_busy", bus.busy_o, 32'h10);
    tick();
    check("order_busy_clr", bus.busy_o, 0);
    $display("txn mul rd=3 then alu rd=4 in order");

    // Fill the tag FIFO: rd10..13 issued, rd14 held until one result pops
    bus.exu_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      drive_op(5'(10 + k), 1'b1, 64'(16'hC000 + k), 4'h1, 1'b0, 1'b0);
    end
    tick();
    bus.dec_valid_i = 1'b0;
    #1;
    check("full_valid_instr", bus.valid_instr_o, 0);
    check("full_dec_ready", bus.dec_ready_o, 0);
    check("full_res_ready", bus.res_ready_o, 1);
    check("full_busy", bus.busy_o, 32'h3C00);
    tick();
    bus.valid_res_i = 1'b1; bus.exu_res_i = 64'hA0;
    #1 check("full_pop_cycle_valid_instr", bus.valid_instr_o, 0);
    tick();
    bus.valid_res_i = 1'b0;
    #1;
    check("resume_valid_instr", bus.valid_instr_o, 1);
    check("resume_opr_a", bus.opr_a_o, 64'hC004);
    check("full_wb_rd", bus.wb_rd_o, 10);
    check("full_wb_en", bus.wb_en_o, 1);
    check("resume_busy", bus.busy_o, 32'h3C00);
    tick();
    bus.exu_ready_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.valid_res_i = 1'b1; bus.exu_res_i = 64'(8'hA1 + j);
      tick();
      check("drain_wb_en", bus.wb_en_o, 1);
      check("drain_wb_rd", bus.wb_rd_o, 11 + j);
      check("drain_wb_data", bus.wb_data_o, 64'(8'hA1 + j));
    end
    bus.valid_res_i = 1'b0;
    tick();
    check("drain_busy", bus.busy_o, 0);
    check("drain_res_ready", bus.res_ready_o, 0);
    $display("txn tag fifo full and drain rd10..14");

    // Flush with two tags pending and one op held
    bus.exu_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_op(5'(20 + k), 1'b1, 64'(16'hD000 + k), 4'h1, 1'b0, 1'b0);
    end
    tick();
    bus.dec_valid_i = 1'b0; bus.exu_ready_i = 1'b0;
    #1;
    check("preflush_busy", bus.busy_o, 32'h0030_0000);
    check("preflush_valid_instr", bus.valid_instr_o, 1);
    tick();
    flush_i = 1'b1;
    #1;
    check("flush_dec_ready", bus.dec_ready_o, 1);
    check("flush_res_ready", bus.res_ready_o, 1);
    tick();
    flush_i = 1'b0;
    #1;
    check("postflush_busy", bus.busy_o, 0);
    check("postflush_valid_instr", bus.valid_instr_o, 0);
    bus.valid_res_i = 1'b1; bus.exu_res_i = 64'hDEAD;
    #1 check("late_res_ready", bus.res_ready_o, 0);
    tick();
    bus.valid_res_i = 1'b0;
    check("late_wb_en", bus.wb_en_o, 0);
    $display("txn flush with rd20,21 pending and rd22 held");

    // Asynchronous reset in the middle of a DIV
    tick();
    drive_op(5'd9, 1'b1, 64'h9999, 4'h3, 1'b0, 1'b1);
    bus.exu_ready_i = 1'b1;
    tick();
    bus.dec_valid_i = 1'b0;
    tick();
    bus.exu_ready_i = 1'b0;
    #1;
    check("div_busy", bus.busy_o, 32'h200);
    check("div_flag", bus.div_instr_o, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_valid_instr", bus.valid_instr_o, 0);
    check("arst_dec_ready", bus.dec_ready_o, 1);
    check("arst_res_ready", bus.res_ready_o, 0);
    check("arst_busy", bus.busy_o, 0);
    check("arst_wb_en", bus.wb_en_o, 0);
    check("arst_wb_rd", bus.wb_rd_o, 0);
    check("arst_wb_data", bus.wb_data_o, 0);
    check("arst_opr_a", bus.opr_a_o, 0);
    check("arst_div_flag", bus.div_instr_o, 0);
    tick();
    resetn = 1'b1;
    bus.valid_res_i = 1'b1; bus.exu_res_i = 64'h9;
    for (int i = 0; i < 3; i++) begin
      #1 check("post_rst_res_ready", bus.res_ready_o, 0);
      tick();
      check("post_rst_wb_en", bus.wb_en_o, 0);
    end
    bus.valid_res_i = 1'b0;
    $display("txn reset mid div rd=9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
